// File: rtl/port_arbiter_if.sv
// Requester-side handshake and device-side port signals of port_arbiter, bundled with
// modports for the arbiter (slave) and for whatever drives it (master).
interface port_arbiter_if #(
   parameter int WORD_SIZE = 16,
   parameter int NREQ      = 3
);
   logic [NREQ-1:0]           req;
   logic [NREQ-1:0]           we;
   logic [NREQ*WORD_SIZE-1:0] addr;
   logic [NREQ*WORD_SIZE-1:0] wdata;
   logic [NREQ-1:0]           gnt;
   logic [NREQ-1:0]           ack;
   logic [WORD_SIZE-1:0]      rdata;
   logic                      busy;
   logic [WORD_SIZE-1:0]      portaddr;
   logic [WORD_SIZE-1:0]      portval;
   logic                      portget;
   logic                      portset;
   logic [WORD_SIZE-1:0]      portout;

   modport slave (
      input  req, we, addr, wdata, portout,
      output gnt, ack, rdata, busy, portaddr, portval, portget, portset
   );

   modport master (
      output req, we, addr, wdata, portout,
      input  gnt, ack, rdata, busy, portaddr, portval, portget, portset
   );
endinterface

// File: rtl/port_arbiter.sv
// Round-robin arbiter giving NREQ requesters serialised access to a single I/O port device,
// with a fixed number of device wait states per access.
module port_arbiter #(
   parameter int WORD_SIZE   = 16,
   parameter int NREQ        = 3,
   parameter int WAIT_CYCLES = 1
) (
   input  logic          clk,
   input  logic          reset_n,
   port_arbiter_if.slave bus
);
   localparam int         IDX_W     = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_WAIT,
      S_COMPLETE
   } state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     gnt_idx_q, gnt_idx_d;
   logic [IDX_W-1:0]     last_gnt_q, last_gnt_d;
   logic [WORD_SIZE-1:0] addr_q, addr_d;
   logic [WORD_SIZE-1:0] wdata_q, wdata_d;
   logic                 we_q, we_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [WORD_SIZE-1:0] rdata_q, rdata_d;
   logic [1:0]           rst_sync_q, rst_sync_d;

   logic                 arb_en;
   logic [IDX_W-1:0]     win_idx;
   logic                 win_found;
   logic [NREQ-1:0]      gnt_vec;
   logic [NREQ-1:0]      ack_vec;

   logic [WORD_SIZE-1:0] addr_arr  [NREQ];
   logic [WORD_SIZE-1:0] wdata_arr [NREQ];

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_req
         assign addr_arr[gi]  = bus.addr[gi*WORD_SIZE +: WORD_SIZE];
         assign wdata_arr[gi] = bus.wdata[gi*WORD_SIZE +: WORD_SIZE];
         assign gnt_vec[gi]   = (state_q != S_IDLE) && (gnt_idx_q == IDX_W'(gi));
         assign ack_vec[gi]   = (state_q == S_COMPLETE) && (gnt_idx_q == IDX_W'(gi));
      end
   endgenerate

   // Arbitration stays disabled until the released reset has crossed two flops.
   assign rst_sync_d = {rst_sync_q[0], 1'b1};
   assign arb_en     = rst_sync_q[1];

   // Search starts one past the previous winner and wraps, so every requester gets a turn.
   always_comb begin
      int cand;
      cand      = 0;
      win_idx   = last_gnt_q;
      win_found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = int'(last_gnt_q) + k;
         if (cand >= NREQ) begin
            cand = cand - NREQ;
         end
         if (!win_found && bus.req[cand[IDX_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      gnt_idx_d  = gnt_idx_q;
      last_gnt_d = last_gnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      we_d       = we_q;
      cnt_d      = cnt_q;
      rdata_d    = rdata_q;
      unique case (state_q)
         S_IDLE: begin
            if (arb_en && win_found) begin
               gnt_idx_d = win_idx;
               addr_d    = addr_arr[win_idx];
               wdata_d   = wdata_arr[win_idx];
               we_d      = bus.we[win_idx];
               state_d   = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (WAIT_CYCLES > 0) begin
               cnt_d   = WAIT_INIT;
               state_d = S_WAIT;
            end else begin
               state_d = S_COMPLETE;
               if (!we_q) begin
                  rdata_d = bus.portout;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = S_COMPLETE;
               if (!we_q) begin
                  rdata_d = bus.portout;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_COMPLETE: begin
            last_gnt_d = gnt_idx_q;
            state_d    = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         gnt_idx_q  <= '0;
         last_gnt_q <= IDX_W'(NREQ - 1);
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         cnt_q      <= 4'd0;
         rdata_q    <= '0;
         rst_sync_q <= 2'b00;
      end else begin
         state_q    <= state_d;
         gnt_idx_q  <= gnt_idx_d;
         last_gnt_q <= last_gnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         cnt_q      <= cnt_d;
         rdata_q    <= rdata_d;
         rst_sync_q <= rst_sync_d;
      end
   end

   // The latched address/data are driven continuously; strobes qualify them.
   assign bus.gnt      = gnt_vec;
   assign bus.ack      = ack_vec;
   assign bus.rdata    = rdata_q;
   assign bus.busy     = (state_q != S_IDLE);
   assign bus.portaddr = addr_q;
   assign bus.portval  = wdata_q;
   assign bus.portget  = (state_q == S_ACCESS) && !we_q;
   assign bus.portset  = (state_q == S_ACCESS) && we_q;
endmodule

// File: tb/tb_port_arbiter.sv
`timescale 1ns/1ps
// Three port_arbiter instances (WAIT_CYCLES 0, 1, 3) share one stimulus stream; a per-cycle
// transaction-schedule model plus directed literal expectations check every output.
module tb_port_arbiter;
   localparam int            WS   = 16;
   localparam int            NREQ = 3;
   localparam int            NI   = 3;
   localparam int            W_OF [NI] = '{0, 1, 3};
   localparam logic [WS-1:0] KEY  = 16'hBEAF;
   localparam int            NS   = 32;
   localparam int S_GNT = 0, S_ACK = 1, S_RD = 2, S_BUSY = 3;
   localparam int S_PADDR = 4, S_PVAL = 5, S_PGET = 6, S_PSET = 7;

   logic               clk     = 1'b0;
   logic               reset_n = 1'b0;
   logic [NREQ-1:0]    req_s   = '0;
   logic [NREQ-1:0]    we_s    = '0;
   logic [NREQ*WS-1:0] addr_s  = '0;
   logic [NREQ*WS-1:0] wdata_s = '0;

   logic [NREQ-1:0] gnt_o   [NI];
   logic [NREQ-1:0] ack_o   [NI];
   logic [WS-1:0]   rdata_o [NI];
   logic [WS-1:0]   paddr_o [NI];
   logic [WS-1:0]   pval_o  [NI];
   logic            busy_o  [NI];
   logic            pget_o  [NI];
   logic            pset_o  [NI];

   int cyc      = 0;
   int n_checks = 0;
   int n_pass   = 0;

   bit            d_en   [NS];
   int            d_inst [NS];
   int            d_sig  [NS];
   logic [WS-1:0] d_exp  [NS];
   string         d_tag  [NS];
   int            n_slot = 0;

   bit            m_act   [NI];
   int            m_start [NI];
   int            m_own   [NI];
   int            m_last  [NI];
   bit            m_we    [NI];
   logic [WS-1:0] m_addr  [NI];
   logic [WS-1:0] m_data  [NI];
   logic [WS-1:0] m_rd    [NI];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   genvar gi;
   generate
      for (gi = 0; gi < NI; gi++) begin : g_inst
         port_arbiter_if #(.WORD_SIZE(WS), .NREQ(NREQ)) bus ();
         assign bus.req     = req_s;
         assign bus.we      = we_s;
         assign bus.addr    = addr_s;
         assign bus.wdata   = wdata_s;
         assign bus.portout = bus.portaddr ^ KEY;
         port_arbiter #(.WORD_SIZE(WS), .NREQ(NREQ), .WAIT_CYCLES(W_OF[gi])) dut (
            .clk     (clk),
            .reset_n (reset_n),
            .bus     (bus)
         );
         assign gnt_o[gi]   = bus.gnt;
         assign ack_o[gi]   = bus.ack;
         assign rdata_o[gi] = bus.rdata;
         assign paddr_o[gi] = bus.portaddr;
         assign pval_o[gi]  = bus.portval;
         assign busy_o[gi]  = bus.busy;
         assign pget_o[gi]  = bus.portget;
         assign pset_o[gi]  = bus.portset;
      end
   endgenerate

   task automatic check(string tag, int inst, logic [WS-1:0] act, logic [WS-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s inst%0d (W=%0d) cycle %0d: got %h expected %h",
                    tag, inst, W_OF[inst], cyc, act, exp);
   endtask

   function automatic logic [WS-1:0] get_out(int i, int sig);
      case (sig)
         S_GNT:   return WS'(gnt_o[i]);
         S_ACK:   return WS'(ack_o[i]);
         S_RD:    return rdata_o[i];
         S_BUSY:  return WS'(busy_o[i]);
         S_PADDR: return paddr_o[i];
         S_PVAL:  return pval_o[i];
         S_PGET:  return WS'(pget_o[i]);
         default: return WS'(pset_o[i]);
      endcase
   endfunction

   // Model: a transaction started at cycle s is ACCESS at s, WAIT for W cycles, COMPLETE at s+W+1.
   always @(negedge clk) begin
      int w, ph, c;
      bit found;
      logic [NREQ-1:0] e_gnt, e_ack;
      logic e_busy, e_get, e_set, chk_port;
      logic [WS-1:0] e_rd, e_addr, e_val;
      for (int i = 0; i < NI; i++) begin
         w = W_OF[i];
         ph = 0;
         e_gnt = '0; e_ack = '0; e_busy = 1'b0; e_get = 1'b0; e_set = 1'b0;
         chk_port = 1'b0; e_addr = '0; e_val = '0;
         e_rd = m_rd[i];
         if (!reset_n) begin
            e_rd = '0;
            chk_port = 1'b1;
         end else if (m_act[i]) begin
            ph = cyc - m_start[i];
            e_gnt = NREQ'(1) << m_own[i];
            e_busy = 1'b1;
            e_get = (ph == 0) && !m_we[i];
            e_set = (ph == 0) && m_we[i];
            if (ph == w + 1) e_ack = e_gnt;
            chk_port = 1'b1;
            e_addr = m_addr[i];
            e_val = m_data[i];
         end
         check("gnt", i, WS'(gnt_o[i]), WS'(e_gnt));
         check("ack", i, WS'(ack_o[i]), WS'(e_ack));
         check("busy", i, WS'(busy_o[i]), WS'(e_busy));
         check("portget", i, WS'(pget_o[i]), WS'(e_get));
         check("portset", i, WS'(pset_o[i]), WS'(e_set));
         check("rdata", i, rdata_o[i], e_rd);
         if (chk_port) begin
            check("portaddr", i, paddr_o[i], e_addr);
            check("portval", i, pval_o[i], e_val);
         end
         if (!reset_n) begin
            m_act[i] = 1'b0;
            m_last[i] = NREQ - 1;
            m_rd[i] = '0;
         end else if (m_act[i]) begin
            if (ph == w && !m_we[i]) m_rd[i] = m_addr[i] ^ KEY;
            if (ph == w + 1) begin
               m_act[i] = 1'b0;
               m_last[i] = m_own[i];
            end
         end else if (req_s != '0) begin
            found = 1'b0;
            for (int k = 1; k <= NREQ; k++) begin
               c = (m_last[i] + k) % NREQ;
               if (!found && req_s[c]) begin
                  found = 1'b1;
                  m_own[i] = c;
               end
            end
            m_act[i] = 1'b1;
            m_start[i] = cyc + 1;
            m_we[i] = we_s[m_own[i]];
            m_addr[i] = addr_s[m_own[i]*WS +: WS];
            m_data[i] = wdata_s[m_own[i]*WS +: WS];
         end
      end
      for (int s = 0; s < NS; s++) begin
         if (d_en[s]) check(d_tag[s], d_inst[s], get_out(d_inst[s], d_sig[s]), d_exp[s]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      for (int s = 0; s < NS; s++) d_en[s] = 1'b0;
      n_slot = 0;
   endtask

   task automatic want(string tag, int inst, int sig, logic [WS-1:0] v);
      if (n_slot < NS) begin
         d_en[n_slot] = 1'b1;
         d_tag[n_slot] = tag;
         d_inst[n_slot] = inst;
         d_sig[n_slot] = sig;
         d_exp[n_slot] = v;
         n_slot++;
      end
   endtask

   task automatic want_all_zero(string tag);
      for (int i = 0; i < NI; i++) begin
         for (int sg = S_GNT; sg <= S_PSET; sg++) want(tag, i, sg, '0);
      end
   endtask

   task automatic do_reset();
      tick();
      reset_n = 1'b0;
      want_all_zero("reset_zero");
      tick();
      want_all_zero("reset_zero");
      tick();
      reset_n = 1'b1;
      repeat (4) tick();
   endtask

   initial begin
      int L, k, ph;
      logic [WS-1:0] g;
      do_reset();

      // Read by requester 1 at 0x0040; device returns 0x0040 ^ KEY = 0xBEEF.
      tick();
      req_s = 3'b010; we_s = 3'b000; addr_s[1*WS +: WS] = 16'h0040;
      want("rd_idle_busy", 1, S_BUSY, 16'd0);
      for (int cc = 1; cc <= 6; cc++) begin
         tick();
         req_s = '0;
         for (int i = 0; i < NI; i++)
            want("rd_ack", i, S_ACK, (cc == 2 + W_OF[i]) ? 16'd2 : 16'd0);
         if (cc == 1) begin
            want("rd_portget", 1, S_PGET, 16'd1);
            want("rd_portaddr", 1, S_PADDR, 16'h0040);
            want("rd_gnt", 1, S_GNT, 16'd2);
         end
         if (cc == 2) want("rd_portget_off", 1, S_PGET, 16'd0);
         if (cc == 6) for (int i = 0; i < NI; i++) want("rd_rdata", i, S_RD, 16'hBEEF);
      end

      // Write 0x1234 to 0x0002 by requester 0; rdata must stay 0xBEEF.
      tick();
      req_s = 3'b001; we_s = 3'b001; addr_s[0 +: WS] = 16'h0002; wdata_s[0 +: WS] = 16'h1234;
      for (int cc = 1; cc <= 6; cc++) begin
         tick();
         req_s = '0;
         for (int i = 0; i < NI; i++)
            want("wr_ack", i, S_ACK, (cc == 2 + W_OF[i]) ? 16'd1 : 16'd0);
         if (cc == 1) begin
            want("wr_portset", 0, S_PSET, 16'd1);
            want("wr_portval", 0, S_PVAL, 16'h1234);
            want("wr_portget", 0, S_PGET, 16'd0);
         end
         if (cc == 6) for (int i = 0; i < NI; i++) want("wr_rdata_held", i, S_RD, 16'hBEEF);
      end

      // Requester 2 read, req dropped in cycle 2; ack still arrives, rdata = 0x0100 ^ KEY.
      tick();
      req_s = 3'b100; we_s = 3'b000; addr_s[2*WS +: WS] = 16'h0100;
      for (int cc = 1; cc <= 6; cc++) begin
         tick();
         if (cc == 2) req_s = '0;
         for (int i = 0; i < NI; i++)
            want("drop_ack", i, S_ACK, (cc == 2 + W_OF[i]) ? 16'd4 : 16'd0);
         if (cc == 6) for (int i = 0; i < NI; i++) want("drop_rdata", i, S_RD, 16'hBFAF);
      end

      // Requester 1 write; addr/wdata scrambled every cycle after sampling.
      tick();
      req_s = 3'b010; we_s = 3'b010; addr_s[1*WS +: WS] = 16'h0AAA; wdata_s[1*WS +: WS] = 16'h5555;
      for (int cc = 1; cc <= 6; cc++) begin
         tick();
         req_s = '0;
         addr_s[1*WS +: WS] = WS'($urandom);
         wdata_s[1*WS +: WS] = WS'($urandom);
         for (int i = 0; i < NI; i++) begin
            if (cc <= 2 + W_OF[i]) begin
               want("hold_portaddr", i, S_PADDR, 16'h0AAA);
               want("hold_portval", i, S_PVAL, 16'h5555);
            end
         end
      end

      // All three requesting continuously after reset: grants 0,1,2,0,1,2, one idle cycle apart.
      do_reset();
      tick();
      req_s = 3'b111; we_s = 3'b000;
      for (int cc = 1; cc <= 36; cc++) begin
         tick();
         for (int i = 0; i < NI; i++) begin
            L = W_OF[i] + 3;
            k = (cc - 1) / L;
            ph = (cc - 1) % L;
            if (k < 6) begin
               g = 16'd1 << (k % 3);
               want("rr_gnt", i, S_GNT, (ph <= W_OF[i] + 1) ? g : 16'd0);
               want("rr_ack", i, S_ACK, (ph == W_OF[i] + 1) ? g : 16'd0);
               want("rr_busy", i, S_BUSY, (ph != L - 1) ? 16'd1 : 16'd0);
            end
         end
      end
      req_s = '0;
      repeat (8) tick();

      // Reset during the WAIT phase of the W=3 instance aborts everything silently.
      tick();
      req_s = 3'b001; we_s = 3'b000; addr_s[0 +: WS] = 16'h0300;
      tick();
      req_s = '0;
      tick();
      reset_n = 1'b0;
      want_all_zero("abort_zero");
      tick();
      want_all_zero("abort_zero");
      tick();
      reset_n = 1'b1;
      for (int cc = 0; cc < 4; cc++) begin
         tick();
         want("abort_no_ack", 2, S_ACK, 16'd0);
         want("abort_idle", 2, S_BUSY, 16'd0);
      end
      tick();
      req_s = 3'b101;
      tick();
      req_s = '0;
      for (int i = 0; i < NI; i++) want("post_reset_gnt", i, S_GNT, 16'd1);
      repeat (8) tick();

      // Randomised traffic, checked by the model only.
      for (int t = 0; t < 800; t++) begin
         tick();
         if ($urandom_range(0, 7) == 0) req_s = '0;
         else if ($urandom_range(0, 3) != 0) req_s = NREQ'($urandom);
         we_s = NREQ'($urandom);
         for (int j = 0; j < NREQ; j++) begin
            addr_s[j*WS +: WS] = WS'($urandom);
            wdata_s[j*WS +: WS] = WS'($urandom);
         end
      end
      req_s = '0;
      repeat (10) tick();
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/port_arbiter.md
PORT_ARBITER -- requirements
Module: port_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default 16: width of port address and data.
REQ-002 Parameter NREQ, default 3: number of requesters (index 0 = CPU, 1 = DMA, 2 = debug).
REQ-003 Parameter WAIT_CYCLES, default 1: device wait states after the strobe cycle; legal range 0..15.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 req  in  NREQ  per-requester access request, level.
REQ-007 we  in  NREQ  per-requester direction: 1 = write (port set), 0 = read (port get).
REQ-008 addr  in  NREQ*WORD_SIZE  per-requester port address; requester i occupies bits [i*WORD_SIZE +: WORD_SIZE].
REQ-009 wdata  in  NREQ*WORD_SIZE  per-requester write data, same packing as addr.
REQ-010 gnt  out  NREQ  one-hot grant, high from the ACCESS state through the COMPLETE state inclusive.
REQ-011 ack  out  NREQ  one-hot single-cycle completion pulse.
REQ-012 rdata  out  WORD_SIZE  read data, shared by all requesters.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 portaddr / portval  out  WORD_SIZE  device address and write data.
REQ-015 portget / portset  out  1  device read and write strobes.
REQ-016 portout  in  WORD_SIZE  device read data.

Function
REQ-017 FSM states are IDLE, ACCESS, WAIT and COMPLETE; state, grant index, latched address, latched data, latched we, wait counter and rdata are all registered.
REQ-018 IDLE with req == 0: remain in IDLE.
REQ-019 IDLE with any req bit set: choose a winner round-robin, searching from index (last_gnt+1) mod NREQ upward with wrap; latch the winner's addr, wdata and we; go to ACCESS.
REQ-020 Requesters need hold addr, wdata and we valid only in the cycle their request is sampled; later changes do not affect the transaction.
REQ-021 ACCESS lasts exactly one cycle: portget = ~we_l and portset = we_l in this cycle only; portaddr = addr_l and portval = wdata_l.
REQ-022 ACCESS exit: go to WAIT with counter = WAIT_CYCLES-1 when WAIT_CYCLES > 0, otherwise go to COMPLETE.
REQ-023 WAIT: decrement the counter; go to COMPLETE on the cycle the counter is 0.
REQ-024 portaddr and portval hold the latched values in ACCESS and WAIT; portget and portset are 0 outside ACCESS.
REQ-025 Read transactions: rdata captures portout on the edge leaving the last ACCESS/WAIT cycle; rdata is otherwise held, and writes leave it unchanged.
REQ-026 COMPLETE lasts one cycle: ack[gnt_idx] = 1, last_gnt updates to gnt_idx, then go to IDLE; no arbitration occurs in COMPLETE.
REQ-027 Latency: with the request sampled in IDLE at cycle 0, the strobe is in cycle 1 and ack is in cycle 2+WAIT_CYCLES.
REQ-028 A request still held after its ack is treated as a new request in the following IDLE cycle.
REQ-029 Dropping req after the grant does not abort the transaction; ack is still pulsed.
REQ-030 Requests arriving during a transaction wait; the minimum gap between two transactions is one IDLE cycle.
REQ-031 Fairness: with all NREQ requests held continuously, grants rotate 0,1,2,0,... and no requester waits more than NREQ transactions.

Reset
REQ-032 While reset_n = 0: state = IDLE, last_gnt = NREQ-1 (so requester 0 wins first), counter = 0.
REQ-033 While reset_n = 0, all outputs are 0: gnt, ack, rdata, busy, portaddr, portval, portget, portset.
REQ-034 Reset asserted mid-transaction aborts it immediately with no ack and no further strobe; after release the FSM starts in IDLE.
REQ-035 Reset release is synchronised internally; the first arbitration happens no earlier than the second rising edge after reset_n rises.

Verification
REQ-036 WAIT_CYCLES=1; requester 1 read at addr 0x0040 with portout=0xBEEF -> portget high in cycle 1 only, portaddr=0x0040, ack[1] high in cycle 3, rdata=0xBEEF.
REQ-037 WAIT_CYCLES=0; requester 0 write 0x1234 to 0x0002 -> portset pulses in cycle 1 with portval=0x1234, ack[0] high in cycle 2, rdata unchanged.
REQ-038 All three req held for 6 transactions after reset -> grant order 0,1,2,0,1,2; each ack one cycle; busy low for exactly one cycle between transactions.
REQ-039 Requester 2 drops req in cycle 2 of a WAIT_CYCLES=3 read -> ack[2] still pulses in cycle 5 and rdata is updated.
REQ-040 reset_n pulled low during WAIT -> all outputs 0 at once; no ack; after release, requester 0 wins the first contention with requester 2.
REQ-041 Requester 1 addr and wdata changed every cycle after sampling -> portaddr and portval stay at the sampled values through COMPLETE.
